// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage integer ALU plus the RV32M multiply/divide family.
// Integer ops and divide special cases finish in one cycle. MUL*/DIV*/REM*
// use a radix-2 iterative datapath: XLEN CALC steps, then one FIXUP cycle.
// RESULT, ZERO and VALID are registered. BUSY is high while CALC or FIXUP runs.
module alu_mdu #(
   parameter int XLEN = 32
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            START,
   input  logic            FLUSH,
   input  logic [4:0]      SELECT,
   input  logic [XLEN-1:0] DATA1,
   input  logic [XLEN-1:0] DATA2,
   output logic [XLEN-1:0] RESULT,
   output logic            ZERO,
   output logic            BUSY,
   output logic            VALID
);

   localparam int SHW = $clog2(XLEN);

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b01000;
   localparam logic [4:0] OP_SLL  = 5'b00001;
   localparam logic [4:0] OP_SLT  = 5'b00010;
   localparam logic [4:0] OP_SLTU = 5'b00011;
   localparam logic [4:0] OP_XOR  = 5'b00100;
   localparam logic [4:0] OP_SRL  = 5'b00101;
   localparam logic [4:0] OP_SRA  = 5'b01101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_AND  = 5'b00111;
   localparam logic [4:0] OP_FWD  = 5'b01111;

   // Low three bits of the M-extension opcodes, kept in op_q during CALC/FIXUP.
   localparam logic [2:0] M_MUL    = 3'b000;
   localparam logic [2:0] M_MULH   = 3'b001;
   localparam logic [2:0] M_MULHSU = 3'b010;
   localparam logic [2:0] M_MULHU  = 3'b011;
   localparam logic [2:0] M_DIV    = 3'b100;
   localparam logic [2:0] M_DIVU   = 3'b101;
   localparam logic [2:0] M_REM    = 3'b110;
   localparam logic [2:0] M_REMU   = 3'b111;

   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [SHW-1:0]  CNT_LAST = SHW'(XLEN - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      CALC  = 2'b01,
      FIXUP = 2'b10
   } state_e;

   state_e            state_q, state_d;
   logic [SHW-1:0]    cnt_q, cnt_d;
   logic [2*XLEN-1:0] acc_q, acc_d;      // product, or {remainder, quotient}
   logic [XLEN-1:0]   opnd_q, opnd_d;    // multiplicand / divisor magnitude
   logic [2:0]        op_q, op_d;
   logic              neg_q, neg_d;      // sign correction applied at FIXUP
   logic [XLEN-1:0]   result_q, result_d;
   logic              zero_q, zero_d;
   logic              valid_q, valid_d;

   // Decode and single-cycle results
   logic [SHW-1:0]  shamt;
   logic            accept;
   logic            is_mdu, is_div;
   logic            a_signed, b_signed, sign_a, sign_b;
   logic [XLEN-1:0] mag_a, mag_b;
   logic            div_by_zero, div_ovf, special, launch, start_neg;
   logic [XLEN-1:0] alu_res, special_res, single_res;

   // Iterative datapath
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_top;
   logic [XLEN+1:0]   div_diff;
   logic              div_borrow;
   logic [XLEN-1:0]   div_rem_next;
   logic [2*XLEN-1:0] mul_fix;
   logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;
   logic              unused_diff_msb;

   // Operand decode, special-case detection and the single-cycle ALU.
   // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
   always_comb begin
      shamt      = DATA2[SHW-1:0];
      accept     = START && !FLUSH && (state_q == IDLE);
      is_mdu     = (SELECT[4:3] == 2'b10);
      is_div     = is_mdu && SELECT[2];
      a_signed   = is_mdu && (SELECT[2:0] inside {M_MUL, M_MULH, M_MULHSU, M_DIV, M_REM});
      b_signed   = is_mdu && (SELECT[2:0] inside {M_MUL, M_MULH, M_DIV, M_REM});
      sign_a     = a_signed && DATA1[XLEN-1];
      sign_b     = b_signed && DATA2[XLEN-1];
      mag_a      = sign_a ? -DATA1 : DATA1;
      mag_b      = sign_b ? -DATA2 : DATA2;

      // Division by zero and signed overflow never enter CALC.
      div_by_zero = is_div && (DATA2 == '0);
      div_ovf     = is_div && !SELECT[0] && (DATA1 == MOST_NEG) && (DATA2 == '1);
      special     = div_by_zero || div_ovf;
      launch      = is_mdu && !special;

      // Remainder keeps the dividend's sign; quotient and product take the XOR.
      start_neg = (is_div && SELECT[1]) ? sign_a : (sign_a ^ sign_b);

      special_res = '0;
      if (div_by_zero) begin
         special_res = SELECT[1] ? DATA1 : '1;
      end else if (div_ovf) begin
         special_res = SELECT[1] ? '0 : MOST_NEG;
      end

      alu_res = '0;
      case (SELECT)
         OP_ADD:  alu_res = DATA1 + DATA2;
         OP_SUB:  alu_res = DATA1 - DATA2;
         OP_SLL:  alu_res = DATA1 << shamt;
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(DATA1) < $signed(DATA2)};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, DATA1 < DATA2};
         OP_XOR:  alu_res = DATA1 ^ DATA2;
         OP_SRL:  alu_res = DATA1 >> shamt;
         OP_SRA:  alu_res = $signed(DATA1) >>> shamt;
         OP_OR:   alu_res = DATA1 | DATA2;
         OP_AND:  alu_res = DATA1 & DATA2;
         OP_FWD:  alu_res = DATA2;
         default: alu_res = '0;
      endcase

      single_res = is_mdu ? special_res : alu_res;
   end

   // One radix-2 step of each algorithm, plus the FIXUP sign correction.
   always_comb begin
      // Shift-add: add the multiplicand into the upper half when the current
      // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
      mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

      // Restoring division: partial remainder shifted left with the next dividend bit.
      div_top      = acc_q[2*XLEN-1:XLEN-1];
      div_diff     = {1'b0, div_top} - {2'b00, opnd_q};
      div_borrow   = div_diff[XLEN+1];
      div_rem_next = div_borrow ? div_top[XLEN-1:0] : div_diff[XLEN-1:0];
      // A non-borrowing difference is below the divisor, so its bit XLEN is zero.
      unused_diff_msb = div_diff[XLEN];

      mul_fix  = neg_q ? -acc_q : acc_q;
      quot_fix = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

      fix_res = '0;
      case (op_q)
         M_MUL:                      fix_res = mul_fix[XLEN-1:0];
         M_MULH, M_MULHSU, M_MULHU:  fix_res = mul_fix[2*XLEN-1:XLEN];
         M_DIV, M_DIVU:              fix_res = quot_fix;
         default:                    fix_res = rem_fix;
      endcase
   end

   // State and datapath registers; RESET wins over everything.
   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b1;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         valid_q  <= valid_d;
      end
   end

   // Next-state logic; FLUSH returns to IDLE from any state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept && launch) state_d = CALC;
         CALC:    if (cnt_q == CNT_LAST) state_d = FIXUP;
         FIXUP:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (FLUSH) state_d = IDLE;
   end

   // Datapath and result updates per state; a FLUSH cycle changes nothing visible.
   always_comb begin
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      op_d     = op_q;
      neg_d    = neg_q;
      result_d = result_q;
      zero_d   = zero_q;
      valid_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (launch) begin
                  acc_d  = {{XLEN{1'b0}}, mag_a};
                  opnd_d = mag_b;
                  op_d   = SELECT[2:0];
                  neg_d  = start_neg;
                  cnt_d  = '0;
               end else begin
                  result_d = single_res;
                  zero_d   = (single_res == '0);
                  valid_d  = 1'b1;
               end
            end
         end
         CALC: begin
            if (!FLUSH) begin
               cnt_d = cnt_q + 1'b1;
               if (op_q[2]) begin
                  acc_d = {div_rem_next, acc_q[XLEN-2:0], !div_borrow};
               end else begin
                  acc_d = {mul_sum, acc_q[XLEN-1:1]};
               end
            end
         end
         FIXUP: begin
            if (!FLUSH) begin
               result_d = fix_res;
               zero_d   = (fix_res == '0);
               valid_d  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Registered outputs; BUSY covers both iterative states.
   always_comb begin
      RESULT = result_q;
      ZERO   = zero_q;
      VALID  = valid_q;
      BUSY   = (state_q == CALC) || (state_q == FIXUP);
   end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: scoreboard of expected results pushed at
// issue and popped when VALID rises, with per-scenario tasks.
module tb_alu_mdu;
   localparam int XLEN = 32;

   localparam logic [4:0] ADD = 5'b00000, SUB = 5'b01000, SLL = 5'b00001, SLT = 5'b00010;
   localparam logic [4:0] SLTU = 5'b00011, XOR_ = 5'b00100, SRL = 5'b00101, SRA = 5'b01101;
   localparam logic [4:0] OR_ = 5'b00110, AND_ = 5'b00111, FWD = 5'b01111;
   localparam logic [4:0] MUL = 5'b10000, MULH = 5'b10001, MULHSU = 5'b10010, MULHU = 5'b10011;
   localparam logic [4:0] DIV = 5'b10100, DIVU = 5'b10101, REM = 5'b10110, REMU = 5'b10111;
   localparam logic [31:0] MIN = 32'h8000_0000;

   logic        CLK = 1'b0;
   logic        RESET, START, FLUSH;
   logic [4:0]  SELECT;
   logic [31:0] DATA1, DATA2, RESULT;
   logic        ZERO, BUSY, VALID;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic [31:0] res;
      int          lat;
      string       name;
   } exp_t;
   exp_t sb_q[$];

   alu_mdu #(.XLEN(XLEN)) dut (
      .CLK(CLK), .RESET(RESET), .START(START), .FLUSH(FLUSH), .SELECT(SELECT),
      .DATA1(DATA1), .DATA2(DATA2), .RESULT(RESULT), .ZERO(ZERO), .BUSY(BUSY), .VALID(VALID)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model, written from the instruction semantics.
   function automatic logic [31:0] model(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] sa, sb, ua, ub, p;
      logic [4:0]  sh;
      logic        ovf;
      sh  = b[4:0];
      sa  = {{32{a[31]}}, a};
      sb  = {{32{b[31]}}, b};
      ua  = {32'b0, a};
      ub  = {32'b0, b};
      ovf = (a == MIN) && (b == 32'hFFFF_FFFF);
      case (sel)
         ADD:    return a + b;
         SUB:    return a - b;
         SLL:    return a << sh;
         SLT:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         SLTU:   return (a < b) ? 32'd1 : 32'd0;
         XOR_:   return a ^ b;
         SRL:    return a >> sh;
         SRA:    return $signed(a) >>> sh;
         OR_:    return a | b;
         AND_:   return a & b;
         FWD:    return b;
         MUL:    begin p = ua * ub; return p[31:0]; end
         MULH:   begin p = sa * sb; return p[63:32]; end
         MULHSU: begin p = sa * ub; return p[63:32]; end
         MULHU:  begin p = ua * ub; return p[63:32]; end
         DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? MIN : $signed(a) / $signed(b);
         DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         REM:    return (b == 0) ? a : ovf ? 32'd0 : $signed(a) % $signed(b);
         REMU:   return (b == 0) ? a : a % b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic int model_lat(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
      if (sel[4:3] != 2'b10) return 1;
      if (sel[2] && (b == 0 || (!sel[0] && a == MIN && b == 32'hFFFF_FFFF))) return 1;
      return 34;
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Drive one START cycle, then scramble the operands to prove they are not reused.
   task automatic issue(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
      SELECT = sel;
      DATA1  = a;
      DATA2  = b;
      START  = 1'b1;
      step();
      START  = 1'b0;
      SELECT = 5'($urandom);
      DATA1  = $urandom;
      DATA2  = $urandom;
   endtask

   // Wait for VALID, pop the scoreboard and compare; optionally pulse START mid-op.
   task automatic collect(input int poke_at);
      exp_t        e;
      int          busy_cnt;
      bit          got;
      logic [31:0] held;
      busy_cnt = 0;
      got      = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         if (BUSY) busy_cnt++;
         if (VALID) begin
            got = 1'b1;
            if (sb_q.size() == 0) begin
               total++;
               $display("FAIL unexpected VALID: got result %h with nothing expected", RESULT);
               break;
            end
            e = sb_q.pop_front();
            total++;
            if (RESULT !== e.res) $display("FAIL %s result: got %h expected %h", e.name, RESULT, e.res);
            else passed++;
            total++;
            if (ZERO !== (e.res == 0)) $display("FAIL %s zero: got %b expected %b", e.name, ZERO, e.res == 0);
            else passed++;
            total++;
            if (k != e.lat) $display("FAIL %s latency: got %0d expected %0d", e.name, k, e.lat);
            else passed++;
            total++;
            if (busy_cnt != ((e.lat == 1) ? 0 : e.lat - 1))
               $display("FAIL %s busy cycles: got %0d expected %0d", e.name, busy_cnt, (e.lat == 1) ? 0 : e.lat - 1);
            else passed++;
            held = RESULT;
            START = 1'b0;
            step();
            total++;
            if (VALID !== 1'b0 || RESULT !== held)
               $display("FAIL %s pulse/hold: got valid=%b result=%h expected valid=0 result=%h", e.name, VALID, RESULT, held);
            else passed++;
            break;
         end
         START = (k == poke_at);
         if (k == poke_at) begin
            SELECT = ADD;
            DATA1  = 32'd1;
            DATA2  = 32'd1;
         end
         step();
      end
      START = 1'b0;
      if (!got) begin
         total++;
         $display("FAIL timeout: got no VALID within 60 cycles, expected one");
         if (sb_q.size() != 0) void'(sb_q.pop_front());
      end
   endtask

   task automatic run_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat, input string name, input int poke_at);
      exp_t e;
      e.res  = res;
      e.lat  = lat;
      e.name = name;
      sb_q.push_back(e);
      issue(sel, a, b);
      collect(poke_at);
   endtask

   task automatic expect_quiet(input int cycles, input string name);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         if (VALID) seen++;
         step();
      end
      total++;
      if (seen != 0) $display("FAIL %s stray VALID: got %0d expected 0", name, seen);
      else passed++;
   endtask

   task automatic test_reset();
      RESET = 1'b1; START = 1'b0; FLUSH = 1'b0;
      SELECT = '0; DATA1 = '0; DATA2 = '0;
      step();
      step();
      RESET = 1'b0;
      total++; if (RESULT !== 32'd0) $display("FAIL reset result: got %h expected 0", RESULT); else passed++;
      total++; if (ZERO !== 1'b1) $display("FAIL reset zero: got %b expected 1", ZERO); else passed++;
      total++; if (BUSY !== 1'b0) $display("FAIL reset busy: got %b expected 0", BUSY); else passed++;
      total++; if (VALID !== 1'b0) $display("FAIL reset valid: got %b expected 0", VALID); else passed++;
   endtask

   task automatic test_alu();
      run_op(ADD,  32'h7FFF_FFFF, 32'h1,  32'h8000_0000, 1, "add_wrap", 0);
      run_op(SUB,  32'd5, 32'd5,           32'd0,         1, "sub_zero", 0);
      run_op(SRA,  32'h8000_0000, 32'h21,  32'hC000_0000, 1, "sra_shamt", 0);
      run_op(SLT,  32'hFFFF_FFFF, 32'd1,   32'd1,         1, "slt", 0);
      run_op(SLTU, 32'hFFFF_FFFF, 32'd1,   32'd0,         1, "sltu", 0);
      run_op(SLL,  32'd1, 32'hFFFF_FFFF,   32'h8000_0000, 1, "sll31", 0);
      run_op(SRL,  32'h8000_0000, 32'h3F,  32'd1,         1, "srl31", 0);
      run_op(XOR_, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1, "xor", 0);
      run_op(OR_,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1, "or", 0);
      run_op(AND_, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1, "and", 0);
      run_op(FWD,  32'h1234_5678, 32'hCAFE_F00D, 32'hCAFE_F00D, 1, "fwd", 0);
      run_op(5'b11000, 32'd3, 32'd4,       32'd0,         1, "undef_11000", 0);
      run_op(5'b01001, 32'd3, 32'd4,       32'd0,         1, "undef_01001", 0);
   endtask

   task automatic test_mul();
      run_op(MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh_min", 0);
      run_op(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu", 0);
      run_op(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu", 0);
      run_op(MUL,    32'h0001_0000, 32'h0001_0000, 32'd0,         34, "mul_lo_zero", 0);
      run_op(MUL,    32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 34, "mul_neg", 0);
   endtask

   task automatic test_div();
      run_op(DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div_neg", 0);
      run_op(REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem_neg", 0);
      run_op(DIVU, 32'd100, 32'd7,       32'd14,        34, "divu", 0);
      run_op(REMU, 32'd100, 32'd7,       32'd2,         34, "remu", 0);
      run_op(DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, "div_negdiv", 0);
      run_op(REM,  32'd7, 32'hFFFF_FFFE, 32'd1,         34, "rem_negdiv", 0);
      run_op(DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, "divu_max", 0);
   endtask

   task automatic test_special();
      run_op(DIV,  32'd5, 32'd0,                 32'hFFFF_FFFF, 1, "div_by_zero", 0);
      run_op(REMU, 32'd9, 32'd0,                 32'd9,         1, "remu_by_zero", 0);
      run_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf", 0);
      run_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, "rem_ovf", 0);
      // Unsigned forms of the same operands are ordinary iterative divides.
      run_op(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34, "divu_not_ovf", 0);
      run_op(REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, "remu_not_ovf", 0);
   endtask

   task automatic test_handshake();
      run_op(DIVU, 32'd100, 32'd7, 32'd14, 34, "start_during_calc", 5);

      // FLUSH in CALC cycle 10, then an ADD the following cycle.
      run_op(ADD, 32'd2, 32'd3, 32'd5, 1, "pre_flush_add", 0);
      issue(MUL, 32'd3, 32'd5);
      for (int i = 1; i < 10; i++) step();
      FLUSH = 1'b1;
      step();
      FLUSH = 1'b0;
      total++; if (BUSY !== 1'b0) $display("FAIL flush_calc busy: got %b expected 0", BUSY); else passed++;
      total++; if (VALID !== 1'b0) $display("FAIL flush_calc valid: got %b expected 0", VALID); else passed++;
      total++; if (RESULT !== 32'd5) $display("FAIL flush_calc result: got %h expected 5", RESULT); else passed++;
      run_op(ADD, 32'd10, 32'd20, 32'd30, 1, "add_after_flush", 0);
      expect_quiet(30, "flush_calc");

      // FLUSH during FIXUP suppresses the VALID.
      run_op(ADD, 32'd4, 32'd4, 32'd8, 1, "pre_fixup_add", 0);
      issue(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      for (int i = 1; i < 33; i++) step();
      total++; if (BUSY !== 1'b1) $display("FAIL fixup busy: got %b expected 1", BUSY); else passed++;
      FLUSH = 1'b1;
      step();
      FLUSH = 1'b0;
      total++; if (VALID !== 1'b0) $display("FAIL flush_fixup valid: got %b expected 0", VALID); else passed++;
      total++; if (RESULT !== 32'd8) $display("FAIL flush_fixup result: got %h expected 8", RESULT); else passed++;
      total++; if (BUSY !== 1'b0) $display("FAIL flush_fixup busy: got %b expected 0", BUSY); else passed++;
      expect_quiet(5, "flush_fixup");

      // START together with FLUSH in IDLE: neither a single-cycle nor an iterative op starts.
      SELECT = ADD; DATA1 = 32'd100; DATA2 = 32'd1;
      START = 1'b1; FLUSH = 1'b1;
      step();
      START = 1'b0; FLUSH = 1'b0;
      total++; if (VALID !== 1'b0) $display("FAIL start_flush_add valid: got %b expected 0", VALID); else passed++;
      total++; if (RESULT !== 32'd8) $display("FAIL start_flush_add result: got %h expected 8", RESULT); else passed++;
      SELECT = MUL; DATA1 = 32'd6; DATA2 = 32'd7;
      START = 1'b1; FLUSH = 1'b1;
      step();
      START = 1'b0; FLUSH = 1'b0;
      total++; if (BUSY !== 1'b0) $display("FAIL start_flush_mul busy: got %b expected 0", BUSY); else passed++;
      expect_quiet(40, "start_flush_mul");
   endtask

   task automatic test_back_to_back();
      logic [4:0]  sels[4];
      logic [31:0] as[4], bs[4];
      exp_t        e;
      sels = '{ADD, SUB, XOR_, FWD};
      as   = '{32'd1, 32'd10, 32'hAAAA_AAAA, 32'd0};
      bs   = '{32'd2, 32'd3,  32'h5555_5555, 32'hDEAD_BEEF};
      for (int i = 0; i < 4; i++) begin
         e.res  = model(sels[i], as[i], bs[i]);
         e.lat  = 1;
         e.name = "b2b";
         sb_q.push_back(e);
         SELECT = sels[i]; DATA1 = as[i]; DATA2 = bs[i]; START = 1'b1;
         step();
         e = sb_q.pop_front();
         total++;
         if (VALID !== 1'b1 || RESULT !== e.res)
            $display("FAIL b2b[%0d]: got valid=%b result=%h expected valid=1 result=%h", i, VALID, RESULT, e.res);
         else passed++;
      end
      START = 1'b0;
      step();
      total++; if (VALID !== 1'b0) $display("FAIL b2b tail valid: got %b expected 0", VALID); else passed++;
   endtask

   task automatic test_random();
      logic [4:0]  codes[19];
      logic [4:0]  sel;
      logic [31:0] a, b;
      int          idx;
      codes = '{ADD, SUB, SLL, SLT, SLTU, XOR_, SRL, SRA, OR_, AND_, FWD,
                MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU};
      for (int n = 0; n < 16; n++) begin
         idx = $urandom_range(0, 19);
         sel = (idx == 19) ? 5'($urandom) : codes[idx];
         case ($urandom_range(0, 4))
            0: a = 32'd0;
            1: a = MIN;
            2: a = 32'hFFFF_FFFF;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 4))
            0: b = 32'd0;
            1: b = MIN;
            2: b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         run_op(sel, a, b, model(sel, a, b), model_lat(sel, a, b), "random", 0);
      end
   endtask

   task automatic test_reset_mid();
      run_op(ADD, 32'd1, 32'd2, 32'd3, 1, "pre_reset_add", 0);
      issue(DIV, 32'hFFFF_FFF9, 32'd2);
      for (int i = 1; i < 15; i++) step();
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      total++; if (BUSY !== 1'b0) $display("FAIL reset_mid busy: got %b expected 0", BUSY); else passed++;
      total++; if (VALID !== 1'b0) $display("FAIL reset_mid valid: got %b expected 0", VALID); else passed++;
      total++; if (RESULT !== 32'd0) $display("FAIL reset_mid result: got %h expected 0", RESULT); else passed++;
      total++; if (ZERO !== 1'b1) $display("FAIL reset_mid zero: got %b expected 1", ZERO); else passed++;
      expect_quiet(30, "reset_mid");
      run_op(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu_after_reset", 0);
   endtask

   initial begin
      test_reset();
      test_alu();
      test_mul();
      test_div();
      test_special();
      test_handshake();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
